// File: rtl/stack_3_pkg.sv
// Shared definitions for the forth-style hardware stacks: default geometry,
// pointer-width helper and the per-cycle operation encoding.
package stack_3_pkg;

   localparam int DSZ_DEF   = 32;
   localparam int DEPTH_DEF = 64;

   // Pointer width for a stack of the given depth (DEPTH is a power of two)
   function automatic int ptr_width(input int depth);
      return $clog2(depth);
   endfunction

   // Operation actually performed this cycle after resolving push/pop/flags
   typedef enum logic [1:0] {
      OP_IDLE    = 2'd0,
      OP_PUSH    = 2'd1,
      OP_POP     = 2'd2,
      OP_REPLACE = 2'd3
   } op_e;

endpackage

// File: rtl/stack_3_ram.sv
// Storage for the entries below top-of-stack: DEPTH-1 words, one synchronous
// write port and one asynchronous read port.
module stack_3_ram #(
   parameter int DSZ   = 32,
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic           clk,
   input  logic           we,
   input  logic [AW-1:0]  waddr,
   input  logic [DSZ-1:0] wdata,
   input  logic [AW-1:0]  raddr,
   output logic [DSZ-1:0] rdata
);

   logic [DSZ-1:0] mem_q [DEPTH-1];

   // Write the spilled TOS word; no reset because the count alone tells which
   // entries are valid
   // NOTE: storage arrays are left unreset so they can map onto RAM macros;
   // validity is tracked by the stack count instead.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/stack_3.sv
// LIFO stack with a registered top-of-stack, spill storage below it, and
// registered overflow / underflow pulses.
module stack_3
   import stack_3_pkg::*;
#(
   parameter  int DSZ   = DSZ_DEF,
   parameter  int DEPTH = DEPTH_DEF,
   localparam int SSZ   = ptr_width(DEPTH)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           push,
   input  logic           pop,
   input  logic [DSZ-1:0] vi,
   output logic [SSZ-1:0] idx,
   output logic [DSZ-1:0] vo,
   output logic           full,
   output logic           empty,
   output logic           ovf,
   output logic           udf
);

   localparam logic [SSZ:0]   CNT_ONE  = (SSZ+1)'(1);
   localparam logic [SSZ:0]   CNT_FULL = (SSZ+1)'(DEPTH);
   localparam logic [SSZ-1:0] A_ONE    = SSZ'(1);
   localparam logic [SSZ-1:0] A_TWO    = SSZ'(2);

   logic [SSZ:0]   count_q, count_d;
   logic [DSZ-1:0] tos_q, tos_d;
   logic           ovf_q, ovf_d;
   logic           udf_q, udf_d;
   op_e            op;
   logic           ram_we;
   logic [DSZ-1:0] ram_rdata;

   assign empty = (count_q == '0);
   assign full  = (count_q == CNT_FULL);
   assign idx   = count_q[SSZ-1:0];
   assign vo    = tos_q;
   assign ovf   = ovf_q;
   assign udf   = udf_q;

   // Resolve the request pair into one operation; push+pop on empty is a push
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // leaves it unassigned, which would otherwise infer a latch.
      op = OP_IDLE;
      if (push && pop && !empty) begin
         op = OP_REPLACE;
      end else if (push) begin
         op = OP_PUSH;
      end else if (pop) begin
         op = OP_POP;
      end
   end

   // Next-state for count, TOS, spill write and the reject pulses
   always_comb begin
      count_d = count_q;
      tos_d   = tos_q;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
      ram_we  = 1'b0;
      case (op)
         OP_REPLACE: tos_d = vi;
         OP_PUSH: begin
            if (full) begin
               ovf_d = 1'b1;
            end else begin
               tos_d   = vi;
               count_d = count_q + CNT_ONE;
               // The old TOS is only meaningful when something was on the stack
               ram_we  = !empty;
            end
         end
         OP_POP: begin
            if (empty) begin
               udf_d = 1'b1;
            end else begin
               count_d = count_q - CNT_ONE;
               tos_d   = (count_q == CNT_ONE) ? '0 : ram_rdata;
            end
         end
         default: ;
      endcase
   end

   // State registers; reset discards the contents immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples its inputs from before the edge.
         count_q <= '0;
         tos_q   <= '0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         tos_q   <= tos_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   // Entries below TOS occupy slots 0..count-2; at full the low pointer bits
   // wrap to 0 so count-2 still lands on DEPTH-2
   stack_3_ram #(
      .DSZ   (DSZ),
      .DEPTH (DEPTH),
      .AW    (SSZ)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (count_q[SSZ-1:0] - A_ONE),
      .wdata (tos_q),
      .raddr (count_q[SSZ-1:0] - A_TWO),
      .rdata (ram_rdata)
   );

endmodule

// File: tb/tb_stack_3.sv
// Scoreboard bench for stack_3: a queue model predicts the outputs of every
// driven cycle and each scenario task compares them after the edge.
module tb_stack_3;

   localparam int DSZ   = 32;
   localparam int DEPTH = 64;

   typedef struct packed {
      logic [31:0] vo;
      logic [5:0]  idx;
      logic        full;
      logic        empty;
      logic        ovf;
      logic        udf;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        push = 1'b0;
   logic        pop = 1'b0;
   logic [31:0] vi = '0;
   logic [5:0]  idx;
   logic [31:0] vo;
   logic        full, empty, ovf, udf;

   logic [31:0] model [$];
   obs_t        sb [$];
   int          n_cmp = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   stack_3 #(.DSZ(DSZ), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .vi    (vi),
      .idx   (idx),
      .vo    (vo),
      .full  (full),
      .empty (empty),
      .ovf   (ovf),
      .udf   (udf)
   );

   function automatic logic [31:0] tv(input int i);
      logic [31:0] ones;
      ones = 32'hFFFF_FFFF;
      return (i < 32) ? (ones >> i) : (ones << (i - 32));
   endfunction

   function automatic obs_t dut_obs();
      obs_t o;
      o.vo = vo; o.idx = idx; o.full = full; o.empty = empty; o.ovf = ovf; o.udf = udf;
      return o;
   endfunction

   function automatic obs_t reset_obs();
      obs_t o;
      o = '0;
      o.empty = 1'b1;
      return o;
   endfunction

   // Drive one cycle, advance the model, queue the prediction, sample after edge
   task automatic step(input logic p, input logic q, input logic [31:0] v);
      obs_t e;
      int   sz;
      bit   f, em;
      sz = model.size();
      f  = (sz == DEPTH);
      em = (sz == 0);
      e  = '0;
      push = p; pop = q; vi = v;
      if (p && q && !em) begin
         model[sz-1] = v;
      end else if (p) begin
         if (f) e.ovf = 1'b1;
         else   model.push_back(v);
      end else if (q) begin
         if (em) e.udf = 1'b1;
         else    void'(model.pop_back());
      end
      sz = model.size();
      e.vo    = (sz == 0) ? 32'h0 : model[sz-1];
      e.idx   = 6'(sz % DEPTH);
      e.full  = (sz == DEPTH);
      e.empty = (sz == 0);
      sb.push_back(e);
      @(posedge clk);
      #1;
      push = 1'b0; pop = 1'b0;
   endtask

   task automatic test_reset();
      obs_t got, exp;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      got = dut_obs(); exp = reset_obs();
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL reset got=%h exp=%h", got, exp);
      end
      rst = 1'b0;
   endtask

   task automatic test_fill();
      obs_t got, exp;
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b1, 1'b0, tv(i));
         exp = sb.pop_front(); got = dut_obs();
         n_cmp++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL fill[%0d] got=%h exp=%h", i, got, exp);
         end
      end
      n_cmp++;
      if (vo !== 32'h8000_0000 || full !== 1'b1 || idx !== 6'd0) begin
         n_err++;
         $display("FAIL fill_top got vo=%h full=%b idx=%0d exp vo=80000000 full=1 idx=0", vo, full, idx);
      end
   endtask

   task automatic test_overflow();
      obs_t got, exp;
      step(1'b1, 1'b0, 32'h1234_5678);
      step(1'b0, 1'b0, 32'h0);
      for (int i = 0; i < 2; i++) begin
         exp = sb.pop_front();
         if (i == 1) begin
            // The pulse cycle was sampled inside step; re-check the idle cycle now
            got = dut_obs();
            n_cmp++;
            if (got !== exp) begin
               n_err++;
               $display("FAIL ovf_clear got=%h exp=%h", got, exp);
            end
         end
      end
   endtask

   task automatic test_ovf_pulse();
      obs_t got, exp;
      step(1'b1, 1'b0, 32'h1234_5678);
      exp = sb.pop_front(); got = dut_obs();
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL ovf_pulse got=%h exp=%h", got, exp);
      end
      step(1'b0, 1'b0, 32'h0);
      exp = sb.pop_front(); got = dut_obs();
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL ovf_idle got=%h exp=%h", got, exp);
      end
   endtask

   task automatic test_drain();
      obs_t got, exp;
      for (int i = 0; i < DEPTH + 1; i++) begin
         step(1'b0, 1'b1, 32'h0);
         exp = sb.pop_front(); got = dut_obs();
         n_cmp++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL drain[%0d] got=%h exp=%h", i, got, exp);
         end
      end
      step(1'b0, 1'b0, 32'h0);
      exp = sb.pop_front(); got = dut_obs();
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL udf_idle got=%h exp=%h", got, exp);
      end
   endtask

   task automatic test_push_pop();
      obs_t got, exp;
      logic p_t [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      logic q_t [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      logic [31:0] v_t [5] = '{32'hA, 32'hB, 32'h0, 32'hC, 32'h0};
      for (int i = 0; i < 5; i++) begin
         step(p_t[i], q_t[i], v_t[i]);
         exp = sb.pop_front(); got = dut_obs();
         n_cmp++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL push_pop[%0d] got=%h exp=%h", i, got, exp);
         end
      end
   endtask

   task automatic test_random();
      obs_t got, exp;
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) == 0), $urandom);
         exp = sb.pop_front(); got = dut_obs();
         n_cmp++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL random[%0d] got=%h exp=%h", i, got, exp);
         end
      end
   endtask

   task automatic test_async_reset();
      obs_t got, exp;
      while (model.size() != 0) begin
         step(1'b0, 1'b1, 32'h0);
         void'(sb.pop_front());
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, tv(i + 40));
         exp = sb.pop_front(); got = dut_obs();
         n_cmp++;
         if (got !== exp) begin
            n_err++;
            $display("FAIL pre_rst[%0d] got=%h exp=%h", i, got, exp);
         end
      end
      #2;
      rst = 1'b1;
      #1;
      model.delete();
      got = dut_obs(); exp = reset_obs();
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL async_rst got=%h exp=%h", got, exp);
      end
      push = 1'bx; pop = 1'bx; vi = 'x;
      @(posedge clk);
      #1;
      got = dut_obs();
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL rst_x_inputs got=%h exp=%h", got, exp);
      end
      push = 1'b0; pop = 1'b0; vi = '0;
      rst = 1'b0;
      step(1'b1, 1'b0, 32'hDEAD_BEEF);
      exp = sb.pop_front(); got = dut_obs();
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL first_push got=%h exp=%h", got, exp);
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_ovf_pulse();
      test_drain();
      test_push_pop();
      test_random();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
